// File: rtl/pe_weight_loader_pkg.sv
// Shared definitions for the PE weight write bus: widths and loader FSM states.
// Also imported by the PE address decode so both sides agree on bus geometry.
package pe_weight_loader_pkg;

    localparam int WEIGHT_DATA_W  = 16;
    localparam int WEIGHT_ADDR_W  = 32;
    localparam int WEIGHT_COUNT_W = 16;
    localparam int HOST_WORD_W    = 32;

    typedef enum logic [1:0] {
        S_ADDR  = 2'd0,
        S_COUNT = 2'd1,
        S_LO    = 2'd2,
        S_HI    = 2'd3
    } loader_state_e;

endpackage

// File: rtl/pe_weight_loader_if.sv
// Host stream plus broadcast weight write bus. The master side is the loader,
// which drives the weight bus and the stream ready.
interface pe_weight_loader_if #(
    parameter int DATA_WIDTH = pe_weight_loader_pkg::WEIGHT_DATA_W,
    parameter int ADDR_WIDTH = pe_weight_loader_pkg::WEIGHT_ADDR_W
);

    logic [pe_weight_loader_pkg::HOST_WORD_W-1:0] in_data;
    logic                                         in_valid;
    logic                                         in_ready;
    logic [DATA_WIDTH-1:0]                        weight_wr_data;
    logic [ADDR_WIDTH-1:0]                        weight_wr_addr;
    logic                                         weight_wr_en;
    logic                                         busy;
    logic                                         done;

    modport master (
        input  in_data, in_valid,
        output in_ready, weight_wr_data, weight_wr_addr, weight_wr_en, busy, done
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, weight_wr_data, weight_wr_addr, weight_wr_en, busy, done
    );

endinterface

// File: rtl/pe_weight_loader.sv
// Unpacks a host word stream (address, count, packed weight pairs) into
// single-cycle weight writes on the bus broadcast to every PE.
module pe_weight_loader
    import pe_weight_loader_pkg::*;
#(
    parameter int DATA_WIDTH  = WEIGHT_DATA_W,
    parameter int ADDR_WIDTH  = WEIGHT_ADDR_W,
    parameter int COUNT_WIDTH = WEIGHT_COUNT_W
) (
    input  logic               clk,
    input  logic               rst,
    pe_weight_loader_if.master bus
);

    loader_state_e           state_r;
    logic [ADDR_WIDTH-1:0]   cur_addr_r;
    logic [COUNT_WIDTH-1:0]  remaining_r;
    logic [DATA_WIDTH-1:0]   held_r;
    logic [DATA_WIDTH-1:0]   wr_data_r;
    logic [ADDR_WIDTH-1:0]   wr_addr_r;
    logic                    wr_en_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    in_ready_s;
    logic                    accept_s;
    logic                    last_s;

    // S_HI replays the held upper half, so the stream is stalled there.
    assign in_ready_s = (state_r != S_HI);
    assign accept_s   = bus.in_valid && in_ready_s;
    assign last_s     = (remaining_r == COUNT_WIDTH'(1));

    // Burst FSM with registered bus outputs; strobe and done default low each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_ADDR;
            cur_addr_r  <= '0;
            remaining_r <= '0;
            held_r      <= '0;
            wr_data_r   <= '0;
            wr_addr_r   <= '0;
            wr_en_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            wr_en_r <= 1'b0;
            done_r  <= 1'b0;
            case (state_r)
                S_ADDR: begin
                    if (accept_s) begin
                        cur_addr_r <= bus.in_data[ADDR_WIDTH-1:0];
                        busy_r     <= 1'b1;
                        state_r    <= S_COUNT;
                    end else begin
                        busy_r     <= 1'b0;
                    end
                end
                S_COUNT: begin
                    if (accept_s) begin
                        remaining_r <= bus.in_data[COUNT_WIDTH-1:0];
                        if (bus.in_data[COUNT_WIDTH-1:0] == COUNT_WIDTH'(0)) begin
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= S_ADDR;
                        end else begin
                            busy_r  <= 1'b1;
                            state_r <= S_LO;
                        end
                    end else begin
                        busy_r <= 1'b1;
                    end
                end
                S_LO: begin
                    busy_r <= 1'b1;
                    if (accept_s) begin
                        wr_en_r     <= 1'b1;
                        wr_data_r   <= bus.in_data[DATA_WIDTH-1:0];
                        wr_addr_r   <= cur_addr_r;
                        held_r      <= bus.in_data[2*DATA_WIDTH-1:DATA_WIDTH];
                        cur_addr_r  <= cur_addr_r + ADDR_WIDTH'(1);
                        remaining_r <= remaining_r - COUNT_WIDTH'(1);
                        if (last_s) begin
                            done_r  <= 1'b1;
                            state_r <= S_ADDR;
                        end else begin
                            state_r <= S_HI;
                        end
                    end else begin
                        state_r <= S_LO;
                    end
                end
                S_HI: begin
                    busy_r      <= 1'b1;
                    wr_en_r     <= 1'b1;
                    wr_data_r   <= held_r;
                    wr_addr_r   <= cur_addr_r;
                    cur_addr_r  <= cur_addr_r + ADDR_WIDTH'(1);
                    remaining_r <= remaining_r - COUNT_WIDTH'(1);
                    if (last_s) begin
                        done_r  <= 1'b1;
                        state_r <= S_ADDR;
                    end else begin
                        state_r <= S_LO;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= S_ADDR;
                end
            endcase
        end
    end

    assign bus.in_ready       = in_ready_s;
    assign bus.weight_wr_data = wr_data_r;
    assign bus.weight_wr_addr = wr_addr_r;
    assign bus.weight_wr_en   = wr_en_r;
    assign bus.busy           = busy_r;
    assign bus.done           = done_r;

endmodule
